// File: rtl/arm_mem_pkg.sv
// Shared memory-subsystem definitions: the SRAM bridge state encoding and the
// byte address at which external SRAM begins.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned BASE_ADDR_DEFAULT = 32'd1024;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side of the data-memory port: request levels in, load data and ready out.
interface sram_controller_if;

  // Request is a level (rd_en/wr_en) held by the master until it sees ready=1;
  // ready=1 with a request present marks the single cycle in which the access completes.
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two timed 16-bit accesses (low half, then
// high half) on an external asynchronous SRAM; ready low freezes the pipeline meanwhile.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned SRAM_DW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   mem,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n,
  output state_t             state
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_WE_END = CW'(WAIT_CYCLES - 2);
  localparam int unsigned WW = SRAM_AW - 1;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_wr_q, op_wr_d;
  logic [WW-1:0]        word_q, word_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [SRAM_DW-1:0]   dq_o_q, dq_o_d;
  logic                 oe_q, oe_d;
  logic                 we_n_q, we_n_d;
  logic [WW-1:0]        word_in;
  logic                 req;

  assign req     = mem.rd_en | mem.wr_en;
  // Offset wraps at 32 bits; address[1:0] falls away with the shift.
  assign word_in = WW'((mem.address - BASE_ADDR) >> 2);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    dq_o_d    = dq_o_q;
    oe_d      = oe_q;
    we_n_d    = we_n_q;
    mem.ready = 1'b0;

    case (state_q)
      IDLE: begin
        mem.ready = ~req;
        if (req) begin
          op_wr_d = mem.wr_en;
          word_d  = word_in;
          wdata_d = mem.write_data;
          state_d = LOW;
          cnt_d   = '0;
          addr_d  = {word_in, 1'b0};
          dq_o_d  = mem.write_data[SRAM_DW-1:0];
          oe_d    = mem.wr_en;
          we_n_d  = ~mem.wr_en;
        end
      end
      LOW: begin
        if (cnt_q == CNT_LAST) begin
          if (!op_wr_q) rdata_d[SRAM_DW-1:0] = sram_dq_i;
          state_d = HIGH;
          cnt_d   = '0;
          addr_d  = {word_q, 1'b1};
          dq_o_d  = wdata_q[2*SRAM_DW-1:SRAM_DW];
          oe_d    = op_wr_q;
          we_n_d  = ~op_wr_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
          // WE rises one cycle before the address moves so data/address hold past it.
          if (cnt_q == CNT_WE_END) we_n_d = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == CNT_LAST) begin
          if (!op_wr_q) rdata_d[2*SRAM_DW-1:SRAM_DW] = sram_dq_i;
          state_d = DONE;
          cnt_d   = '0;
          oe_d    = 1'b0;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_WE_END) we_n_d = 1'b1;
        end
      end
      DONE: begin
        mem.ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
    end
  end

  assign mem.read_data = rdata_q;
  assign sram_addr     = addr_q;
  assign sram_dq_o     = dq_o_q;
  assign sram_dq_oe    = oe_q;
  assign sram_we_n     = we_n_q;
  assign sram_ce_n     = 1'b0;
  assign sram_oe_n     = 1'b0;
  assign sram_ub_n     = 1'b0;
  assign sram_lb_n     = 1'b0;
  assign state         = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural 256Kx16 SRAM, directed scenarios, then random
// word traffic checked against a word-level memory reference.
module tb_sram_controller;
  import arm_mem_pkg::*;

  localparam int W   = 5;
  localparam int LAT = 2 * W + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;
  state_t      dut_state;

  sram_controller_if bus ();

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W), .SRAM_AW(18), .SRAM_DW(16)) dut (
    .clk(clk), .rst(rst), .mem(bus),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
    .state(dut_state)
  );

  always #5 clk = ~clk;

  // sram_model: commits on the WE rising edge while the pad is driven; reads are combinational.
  logic [15:0] sram_mem [0:262143];
  logic        we_n_prev = 1'b1;
  assign sram_dq_i = sram_mem[sram_addr];
  always @(negedge clk) begin
    if (!we_n_prev && sram_we_n && sram_dq_oe) sram_mem[sram_addr] = sram_dq_o;
    we_n_prev = sram_we_n;
  end

  // Reference: word-level memory and the last value a read returned.
  logic [15:0] exp_mem [0:262143];
  logic [31:0] exp_rd = 32'h0;
  int          written_q[$];
  int          total = 0;
  int          bad = 0;

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off >> 2) & 32'h1FFFF) * 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    bus.wr_en      = wr;
    bus.rd_en      = rd;
    bus.address    = a;
    bus.write_data = d;
  endtask

  task automatic idle_req();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  // Called at +1 into an IDLE cycle (from_done=0) or the DONE cycle (from_done=1).
  // Returns at +1 into the DONE cycle with the request still applied.
  task automatic run_op(input string tag, input bit wr, input bit rd,
                        input logic [31:0] a, input logic [31:0] d, input bit from_done);
    int lat, we_lo, we_hi, idx;
    logic [17:0] a_lo, a_hi;
    set_req(wr, rd, a, d);
    if (from_done) step(); else #1;
    check({tag, "_ready_c0"}, 32'(bus.ready), 32'h0);
    lat = -1; we_lo = 0; we_hi = 0; a_lo = '0; a_hi = '0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 1) a_lo = sram_addr;
      if (c == W + 1) a_hi = sram_addr;
      if (!sram_we_n) begin
        if (c <= W) we_lo++; else we_hi++;
      end
      if (bus.ready) begin
        lat = c;
        break;
      end
    end
    idx = idx_of(a);
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_addr_lo"}, 32'(a_lo), 32'(idx));
    check({tag, "_addr_hi"}, 32'(a_hi), 32'(idx + 1));
    check({tag, "_we_lo"}, 32'(we_lo), wr ? 32'(W - 1) : 32'h0);
    check({tag, "_we_hi"}, 32'(we_hi), wr ? 32'(W - 1) : 32'h0);
    if (wr) begin
      exp_mem[idx]     = d[15:0];
      exp_mem[idx + 1] = d[31:16];
      check({tag, "_sram_lo"}, 32'(sram_mem[idx]), 32'(exp_mem[idx]));
      check({tag, "_sram_hi"}, 32'(sram_mem[idx + 1]), 32'(exp_mem[idx + 1]));
    end else begin
      exp_rd = {exp_mem[idx + 1], exp_mem[idx]};
    end
    check({tag, "_rdata"}, bus.read_data, exp_rd);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(bus.ready), 32'h1);
    check({tag, "_we_n"}, 32'(sram_we_n), 32'h1);
    check({tag, "_oe"}, 32'(sram_dq_oe), 32'h0);
    check({tag, "_rdata"}, bus.read_data, 32'h0);
    check({tag, "_addr"}, 32'(sram_addr), 32'h0);
    check({tag, "_state"}, 32'(dut_state), 32'(IDLE));
  endtask

  initial begin
    logic [31:0] a, d;
    bit wr, chain;
    idle_req();
    bus.address    = 32'h0;
    bus.write_data = 32'h0;

    // 1: power-on reset, then reset held 3 cycles in the middle of a write
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check_reset_state("t1_por");
    set_req(1'b1, 1'b0, 32'd1024, 32'h1111_2222);
    repeat (3) step();
    check("t1_busy_we_n", 32'(sram_we_n), 32'h0);
    rst = 1'b1;
    idle_req();
    repeat (3) step();
    check_reset_state("t1_mid");
    rst = 1'b0;
    step();

    // 2: write 0xDEADBEEF @1024
    run_op("t2", 1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1'b0);
    idle_req();
    step();

    // 3: read it back; value held after rd_en drops
    run_op("t3", 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    check("t3_value", bus.read_data, 32'hDEAD_BEEF);
    idle_req();
    step();
    step();
    check("t3_hold", bus.read_data, 32'hDEAD_BEEF);

    // 4: write @1032 with a read chained straight out of DONE
    run_op("t4w", 1'b1, 1'b0, 32'd1032, 32'h1234_5678, 1'b0);
    run_op("t4r", 1'b0, 1'b1, 32'd1032, 32'h0, 1'b1);
    check("t4_value", bus.read_data, 32'h1234_5678);
    idle_req();
    step();

    // 5: rd_en and wr_en together -> write
    run_op("t5", 1'b1, 1'b1, 32'd1028, 32'hA5A5_5A5A, 1'b0);
    check("t5_sram2", 32'(sram_mem[2]), 32'h5A5A);
    check("t5_sram3", 32'(sram_mem[3]), 32'hA5A5);
    check("t5_rdata_kept", bus.read_data, 32'h1234_5678);
    idle_req();
    step();

    // 6: misaligned write @1030, reset at cycle 7 (high half in flight)
    set_req(1'b1, 1'b0, 32'd1030, 32'h0000_FFFF);
    #1;
    for (int c = 1; c <= 7; c++) step();
    rst = 1'b1;
    idle_req();
    step();
    check("t6_state", 32'(dut_state), 32'(IDLE));
    check("t6_we_n", 32'(sram_we_n), 32'h1);
    check("t6_ready", 32'(bus.ready), 32'h1);
    check("t6_sram2", 32'(sram_mem[2]), 32'hFFFF);
    rst = 1'b0;
    exp_rd = 32'h0;
    step();

    // Random traffic over words 16..47
    chain = 1'b0;
    for (int i = 0; i < 24; i++) begin
      wr = (written_q.size() == 0) || ($urandom_range(0, 1) == 1);
      if (wr) begin
        a = 32'd1024 + 32'(4 * $urandom_range(16, 47)) + 32'($urandom_range(0, 3));
        d = $urandom;
        written_q.push_back(int'(a & ~32'h3));
      end else begin
        a = 32'(written_q[$urandom_range(0, written_q.size() - 1)]) + 32'($urandom_range(0, 3));
        d = $urandom;
      end
      run_op($sformatf("rnd%0d", i), wr, ~wr, a, d, chain);
      chain = ($urandom_range(0, 1) == 1);
      if (!chain) begin
        idle_req();
        repeat ($urandom_range(1, 3)) step();
      end
    end
    idle_req();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
